// File: rtl/serial_adder_controller.sv
// Bit-serial adder: one full-adder cell processes the operands LSB first over
// WIDTH cycles, with a start/busy/done handshake and registered sum/cout.
module serial_adder_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int              CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] acc_next;

  // The single shared full-adder cell and the accumulator shift path.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no latch can be inferred.
    bit_s    = op_a[0] ^ op_b[0] ^ carry;
    bit_c    = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
    acc_next = acc >> 1;
    acc_next[WIDTH-1] = bit_s;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        ADD: begin
          acc   <= acc_next;
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= bit_c;
          cnt   <= cnt + 1'b1;
          // The last bit goes straight from the cell into sum, bypassing acc.
          if (cnt == LAST) begin
            sum   <= acc_next;
            cout  <= bit_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
